// File: rtl/mem_bilo_db_rd_ctrl_pkg.sv
// Shared definitions for the deblocked-LCU line-buffer read path.
// Holds the pixel/line widths, the address map of the 208-entry buffer
// (luma, interleaved uv chroma, top lines), the region select encodings,
// the read-controller state encoding and a helper that maps a select
// code to its first/last buffer address.
package mem_bilo_db_rd_ctrl_pkg;

  localparam int PIXEL_WIDTH = 8;
  localparam int LINE_W      = PIXEL_WIDTH * 32;
  localparam int ADDR_W      = 8;

  localparam int LUMA_BASE   = 0;
  localparam int LUMA_NUM    = 128;
  localparam int CHROMA_BASE = 128;
  localparam int CHROMA_NUM  = 64;
  localparam int TOP_BASE    = 192;
  localparam int TOP_NUM     = 16;

  typedef enum logic [1:0] {
    RD_SEL_LUMA   = 2'd0,
    RD_SEL_CHROMA = 2'd1,
    RD_SEL_TOP    = 2'd2,
    RD_SEL_ALL    = 2'd3
  } rd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] last;
  } rd_region_t;

  // Luma and chroma are contiguous, so "all" is simply luma base to chroma end.
  function automatic rd_region_t region_of(input logic [1:0] sel);
    rd_region_t r;
    case (sel)
      RD_SEL_LUMA: begin
        r.base = ADDR_W'(LUMA_BASE);
        r.last = ADDR_W'(LUMA_BASE + LUMA_NUM - 1);
      end
      RD_SEL_CHROMA: begin
        r.base = ADDR_W'(CHROMA_BASE);
        r.last = ADDR_W'(CHROMA_BASE + CHROMA_NUM - 1);
      end
      RD_SEL_TOP: begin
        r.base = ADDR_W'(TOP_BASE);
        r.last = ADDR_W'(TOP_BASE + TOP_NUM - 1);
      end
      default: begin
        r.base = ADDR_W'(LUMA_BASE);
        r.last = ADDR_W'(CHROMA_BASE + CHROMA_NUM - 1);
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_bilo_rd_fifo2.sv
// Two-entry FIFO carrying a line of pixels plus a "last beat" tag.
// Push and pop may happen in the same cycle. The caller guarantees it
// never pushes when full. Head outputs read as zero while empty.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   push, push_data/last   write one entry
//   pop                    remove the head entry
//   head_data/last/valid   current head of the FIFO
//   cnt                    number of stored entries (0..2)
module mem_bilo_rd_fifo2 #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_last,
  output logic         head_valid,
  output logic [1:0]   cnt
);

  logic [W-1:0] data_q [2];
  logic [1:0]   last_q;
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= push_data;
        last_q[wr_ptr_q] <= push_last;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_valid = (cnt_q != 2'd0);
  assign head_data  = head_valid ? data_q[rd_ptr_q] : '0;
  assign head_last  = head_valid & last_q[rd_ptr_q];
  assign cnt        = cnt_q;

endmodule

// File: rtl/mem_bilo_db_rd_ctrl.sv
// Read sequencer for the deblocked-LCU line buffer.
// On start it walks the selected address region in ascending order,
// issuing ren_o/raddr_o, and captures each returned line (1-cycle read
// latency) into a 2-entry FIFO that feeds the output stream.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start_i, sel_i       start pulse and region select (sampled in IDLE only)
//   busy_o, done_o       run in progress / pulse with the last accepted beat
//   ren_o, raddr_o       buffer read request
//   rdata_i              buffer read data, valid the cycle after ren_o
//   data_o, data_valid_o, data_ready_i, data_last_o   output line stream
//   dbg_state_o          current controller state
//
// Stream handshake: a beat transfers in any cycle where data_valid_o and
// data_ready_i are both high; data_o/data_last_o are stable while
// data_valid_o is high and not yet accepted; data_valid_o never depends on
// data_ready_i, and data_last_o is meaningful only with data_valid_o.
module mem_bilo_db_rd_ctrl
  import mem_bilo_db_rd_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        sel_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              ren_o,
  output logic [ADDR_W-1:0] raddr_o,
  input  logic [LINE_W-1:0] rdata_i,
  output logic [LINE_W-1:0] data_o,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic              data_last_o,
  output rd_state_e         dbg_state_o
);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic [1:0]        fifo_cnt;
  logic              pop;
  logic              issue;
  logic              issue_last;
  logic [2:0]        occupancy;
  rd_region_t        region;

  assign region = region_of(sel_i);
  assign pop    = data_valid_o & data_ready_i;

  // Slots already committed after this cycle's pop: stored lines plus the
  // read still in flight. Issuing only while this is below 2 means the
  // returning line always finds room, so rdata_i never needs a stall.
  assign occupancy  = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == ST_RUN) && (occupancy < 3'd2);
  assign issue_last = issue && (addr_q == last_addr_q);

  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (issue_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && data_last_o) begin
          state_d = ST_IDLE;
          done_o  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      last_addr_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
      if (state_q == ST_IDLE && start_i) begin
        addr_q      <= region.base;
        last_addr_q <= region.last;
      end else if (issue && !issue_last) begin
        // The address stays on the final entry once issued; no wrap.
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  mem_bilo_rd_fifo2 #(.W(LINE_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_q),
    .push_data  (rdata_i),
    .push_last  (inflight_last_q),
    .pop        (pop),
    .head_data  (data_o),
    .head_last  (data_last_o),
    .head_valid (data_valid_o),
    .cnt        (fifo_cnt)
  );

  assign ren_o       = issue;
  assign raddr_o     = addr_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bilo_db_rd_ctrl.sv
// Bench for mem_bilo_db_rd_ctrl: a line-buffer model with random contents
// answers reads; expected addresses and beats come from the region table.
module tb_mem_bilo_db_rd_ctrl;
  import mem_bilo_db_rd_ctrl_pkg::*;

  localparam int W = PIXEL_WIDTH * 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [1:0]   sel_i = 2'd0;
  logic         busy_o, done_o, ren_o;
  logic [7:0]   raddr_o;
  logic [W-1:0] rdata_i = '0;
  logic [W-1:0] data_o;
  logic         data_valid_o;
  logic         data_ready_i = 1'b0;
  logic         data_last_o;
  logic [1:0]   dbg_state;

  logic [W-1:0] mem [0:207];
  logic [W:0]   exp_q [$];
  logic [7:0]   addr_q [$];

  int vectors = 0;
  int miscompares = 0;
  int ren_cnt = 0;
  int beat_cnt = 0;
  int cyc_now = 0;
  int first_beat_cyc = 0;
  int last_beat_cyc = 0;
  int cur_num = 0;
  bit run_active = 1'b0;
  bit done_seen = 1'b0;

  mem_bilo_db_rd_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .sel_i        (sel_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .ren_o        (ren_o),
    .raddr_o      (raddr_o),
    .rdata_i      (rdata_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .data_last_o  (data_last_o),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / buffer model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_now <= cyc_now + 1;
    if (ren_o) rdata_i <= mem[raddr_o];
  end

  // ---------------- compare helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_line(input string name, input logic [W:0] act, input logic [W:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Region table straight from the buffer address map.
  function automatic void region(input logic [1:0] sel, output int base, output int num);
    case (sel)
      2'd0:    begin base = 0;   num = 128; end
      2'd1:    begin base = 128; num = 64;  end
      2'd2:    begin base = 192; num = 16;  end
      default: begin base = 0;   num = 192; end
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [W:0] e;
    logic acc;
    logic exp_done;
    if (rst_n) begin
      exp_done = 1'b0;
      acc = data_valid_o && data_ready_i;
      if (ren_o) begin
        ren_cnt++;
        if (addr_q.size() == 0) fail("unexpected_ren");
        else check("raddr", {24'd0, raddr_o}, {24'd0, addr_q.pop_front()});
      end
      if (acc) begin
        if (beat_cnt == 0) first_beat_cyc = cyc_now;
        last_beat_cyc = cyc_now;
        beat_cnt++;
        if (exp_q.size() == 0) fail("extra_beat");
        else begin
          e = exp_q.pop_front();
          check_line("beat", {data_last_o, data_o}, e);
          exp_done = (exp_q.size() == 0);
        end
      end
      if (acc || done_o) check("done", {31'd0, done_o}, {31'd0, exp_done});
      check("busy", {31'd0, busy_o}, {31'd0, run_active});
      if (exp_done) begin
        done_seen  = 1'b1;
        run_active = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called aligned just after a rising edge; leaves aligned the same way.
  task automatic start_run(input logic [1:0] sel);
    int base, num;
    region(sel, base, num);
    for (int i = 0; i < num; i++) begin
      exp_q.push_back({(i == num - 1), mem[base + i]});
      addr_q.push_back(8'(base + i));
    end
    cur_num   = num;
    done_seen = 1'b0;
    ren_cnt   = 0;
    beat_cnt  = 0;
    start_i   = 1'b1;
    sel_i     = sel;
    @(posedge clk); #1;
    start_i    = 1'b0;
    sel_i      = 2'($urandom_range(0, 3));
    run_active = 1'b1;
  endtask

  // mode 0: ready high; 1: ready 1010..; 2: ready low 10 cycles then high;
  // 3: random ready; 4: ready high with a stray start pulse mid-run.
  task automatic wait_done(input int mode, input int budget);
    int cyc = 0;
    while (!done_seen && cyc < budget) begin
      case (mode)
        0: data_ready_i = 1'b1;
        1: data_ready_i = (cyc % 2 == 0);
        2: begin
          if (cyc == 10) check("stall_ren_count", ren_cnt, 2);
          data_ready_i = (cyc >= 10);
        end
        3: data_ready_i = 1'($urandom_range(0, 1));
        default: begin
          data_ready_i = 1'b1;
          start_i = (cyc == 40);
          if (cyc == 40) sel_i = 2'd2;
        end
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    if (!done_seen) fail("timeout_waiting_done");
    check("beats_left", exp_q.size(), 0);
    check("addrs_left", addr_q.size(), 0);
    check("beat_count", beat_cnt, cur_num);
    if (mode == 0 || mode == 4)
      check("back_to_back_span", last_beat_cyc - first_beat_cyc, cur_num - 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ren"}, {31'd0, ren_o}, 32'd0);
    check({tag, "_raddr"}, {24'd0, raddr_o}, 32'd0);
    check({tag, "_valid"}, {31'd0, data_valid_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_done"}, {31'd0, done_o}, 32'd0);
    check_line({tag, "_data_last"}, {data_last_o, data_o}, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 208; i++)
      for (int w = 0; w < W / 32; w++)
        mem[i][w*32 +: 32] = $urandom();

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("in_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after_reset");

    // luma, ready held high
    data_ready_i = 1'b1;
    start_run(2'd0);
    wait_done(0, 600);

    // chroma, ready toggling
    start_run(2'd1);
    wait_done(1, 600);

    // top lines, sink stalled for 10 cycles after start
    data_ready_i = 1'b0;
    start_run(2'd2);
    wait_done(2, 600);

    // luma+chroma with an ignored start in the middle
    data_ready_i = 1'b1;
    start_run(2'd3);
    wait_done(4, 900);

    // reset in the middle of a luma run
    data_ready_i = 1'b1;
    start_run(2'd0);
    for (int c = 0; c < 500 && beat_cnt < 50; c++) begin
      @(posedge clk); #1;
    end
    check("beats_before_reset", beat_cnt, 50);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_run_reset");
    exp_q.delete();
    addr_q.delete();
    run_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // clean luma run after the abort, random backpressure
    start_run(2'd0);
    wait_done(3, 1500);

    // back-to-back runs, each started the cycle after the previous done
    start_run(2'd2);
    wait_done(0, 600);
    start_run(2'd1);
    wait_done(3, 1000);
    start_run(2'd3);
    wait_done(3, 2500);

    repeat (4) @(posedge clk);
    #1;
    check("final_busy", {31'd0, busy_o}, 32'd0);
    check("final_valid", {31'd0, data_valid_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
